// File: rtl/cflog_pkg.sv
// Shared definitions for the CF-Log UART transmit path: FSM encoding and build constants.
package cflog_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam int unsigned UART_DATA_BITS   = 8;
  // 8 MHz mclk / 115200 baud
  localparam int unsigned DEFAULT_BAUD_DIV = 69;

endpackage

// File: rtl/cflog_uart_tx_if.sv
// Byte request and status bundle between the readout controller and the UART transmitter.
interface cflog_uart_tx_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             tx_trigger;
  logic [7:0]       tx_byte;
  logic             tx_enable;
  logic             uart_txd;
  logic             tx_busy;
  logic             hold_full;
  logic             overrun;
  logic [CNT_W-1:0] bytes_sent;

  modport master (
    output tx_trigger, tx_byte, tx_enable,
    input  uart_txd, tx_busy, hold_full, overrun, bytes_sent
  );

  modport slave (
    input  tx_trigger, tx_byte, tx_enable,
    output uart_txd, tx_busy, hold_full, overrun, bytes_sent
  );

endinterface

// File: rtl/cflog_baud_tick.sv
// Bit-period counter: flags the last cycle of each UART bit; cleared synchronously on frame load.
module cflog_baud_tick #(
  parameter int unsigned BAUD_DIV = 69
) (
  input  logic mclk,
  input  logic puc_rst,
  input  logic i_clr,
  input  logic i_run,
  output logic o_bit_end
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LastCnt = CW'(BAUD_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;

  assign o_bit_end = (r_cnt == LastCnt);

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_clr || o_bit_end) begin
      w_cnt_d = '0;
    end else if (i_run) begin
      w_cnt_d = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

endmodule

// File: rtl/cflog_uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register, sticky overrun and a sent-byte counter.
module cflog_uart_tx
  import cflog_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int unsigned CNT_W    = 16
) (
  input logic            mclk,
  input logic            puc_rst,
  cflog_uart_tx_if.slave bus
);

  tx_state_e        r_state, w_state_d;
  logic [7:0]       r_hold_reg;
  logic [7:0]       r_shreg, w_shreg_d;
  logic [2:0]       r_bit_idx, w_bit_idx_d;
  logic             r_hold_full;
  logic             r_overrun;
  logic             r_txd, w_txd_d;
  logic [CNT_W-1:0] r_bytes_sent;

  logic w_bit_end;
  logic w_req;
  logic w_load;
  logic w_accept;

  assign w_req    = bus.tx_trigger & bus.tx_enable;
  // The holding register frees up in the same cycle the shifter takes it.
  assign w_load   = r_hold_full & ((r_state == StIdle) | ((r_state == StStop) & w_bit_end));
  assign w_accept = w_req & (~r_hold_full | w_load);

  cflog_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .mclk      (mclk),
    .puc_rst   (puc_rst),
    .i_clr     (w_load),
    .i_run     (r_state != StIdle),
    .o_bit_end (w_bit_end)
  );

  always_comb begin
    w_state_d   = r_state;
    w_shreg_d   = r_shreg;
    w_bit_idx_d = r_bit_idx;
    case (r_state)
      StIdle: begin
        if (w_load) begin
          w_state_d = StStart;
          w_shreg_d = r_hold_reg;
        end
      end
      StStart: begin
        if (w_bit_end) begin
          w_state_d   = StData;
          w_bit_idx_d = '0;
        end
      end
      StData: begin
        if (w_bit_end) begin
          w_shreg_d   = {1'b0, r_shreg[7:1]};
          w_bit_idx_d = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
            w_state_d = StStop;
          end
        end
      end
      StStop: begin
        if (w_bit_end) begin
          if (w_load) begin
            w_state_d = StStart;
            w_shreg_d = r_hold_reg;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Line level follows the next state so it changes on the same edge as the FSM.
    case (w_state_d)
      StStart: w_txd_d = 1'b0;
      StData:  w_txd_d = w_shreg_d[0];
      default: w_txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_state      <= StIdle;
      r_hold_reg   <= '0;
      r_shreg      <= '0;
      r_bit_idx    <= '0;
      r_hold_full  <= 1'b0;
      r_overrun    <= 1'b0;
      r_txd        <= 1'b1;
      r_bytes_sent <= '0;
    end else begin
      r_state     <= w_state_d;
      r_shreg     <= w_shreg_d;
      r_bit_idx   <= w_bit_idx_d;
      r_txd       <= w_txd_d;
      r_hold_full <= w_accept | (r_hold_full & ~w_load);
      if (w_accept) begin
        r_hold_reg <= bus.tx_byte;
      end
      if (w_req & r_hold_full & ~w_load) begin
        r_overrun <= 1'b1;
      end
      if ((r_state == StStop) && w_bit_end) begin
        r_bytes_sent <= r_bytes_sent + CNT_W'(1);
      end
    end
  end

  assign bus.uart_txd   = r_txd;
  assign bus.tx_busy    = (r_state != StIdle) | r_hold_full;
  assign bus.hold_full  = r_hold_full;
  assign bus.overrun    = r_overrun;
  assign bus.bytes_sent = r_bytes_sent;

endmodule

// File: tb/tb_cflog_uart_tx.sv
// Directed bench for cflog_uart_tx at BAUD_DIV=4: framing, back-to-back, overrun, enable, reset.
module tb_cflog_uart_tx;

  localparam int unsigned BaudDiv  = 4;
  localparam int unsigned FrameLen = 10 * BaudDiv;

  logic mclk    = 1'b0;
  logic puc_rst = 1'b1;
  int   total   = 0;
  int   bad     = 0;

  cflog_uart_tx_if #(.CNT_W(16)) bus ();

  cflog_uart_tx #(
    .BAUD_DIV (BaudDiv),
    .CNT_W    (16)
  ) dut (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .bus     (bus)
  );

  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Expected line: idle at index 0, then nf frames back to back from index 1, idle after.
  function automatic logic [159:0] line_model(input int nf, input logic [7:0] b0,
                                              input logic [7:0] b1, input logic [7:0] b2);
    logic [159:0] v;
    logic [9:0]   fr;
    logic [7:0]   bs[3];
    v = '1;
    bs[0] = b0;
    bs[1] = b1;
    bs[2] = b2;
    for (int f = 0; f < nf; f++) begin
      fr = {1'b1, bs[f], 1'b0};
      for (int k = 0; k < 10; k++)
        for (int j = 0; j < int'(BaudDiv); j++)
          v[1 + f * int'(FrameLen) + k * int'(BaudDiv) + j] = fr[k];
    end
    return v;
  endfunction

  // Pulses tx_trigger at cycles t0/t1/t2 and records status after every edge.
  task automatic drive_and_capture(input int n, input int t0, input logic [7:0] b0,
                                   input int t1, input logic [7:0] b1,
                                   input int t2, input logic [7:0] b2,
                                   output logic [159:0] v, output logic [159:0] hv,
                                   output logic [159:0] ov, output logic [159:0] bv);
    v  = '1;
    hv = '0;
    ov = '0;
    bv = '0;
    for (int c = 0; c < n; c++) begin
      bus.tx_trigger = (c == t0) || (c == t1) || (c == t2);
      bus.tx_byte    = (c == t1) ? b1 : (c == t2) ? b2 : b0;
      tick();
      bus.tx_trigger = 1'b0;
      v[c]  = bus.uart_txd;
      hv[c] = bus.hold_full;
      ov[c] = bus.overrun;
      bv[c] = bus.tx_busy;
    end
  endtask

  task automatic do_reset();
    bus.tx_trigger = 1'b0;
    puc_rst = 1'b1;
    tick();
    tick();
    puc_rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({bus.uart_txd, bus.tx_busy, bus.hold_full, bus.overrun, bus.bytes_sent} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL reset_hold: got txd=%b busy=%b hold=%b ovr=%b sent=%0d want 1 0 0 0 0",
               bus.uart_txd, bus.tx_busy, bus.hold_full, bus.overrun, bus.bytes_sent);
    end
    puc_rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      total++;
      if ({bus.uart_txd, bus.tx_busy, bus.bytes_sent} !== {1'b1, 1'b0, 16'd0}) begin
        bad++;
        $display("FAIL reset_idle c=%0d: got txd=%b busy=%b sent=%0d want 1 0 0",
                 c, bus.uart_txd, bus.tx_busy, bus.bytes_sent);
      end
    end
  endtask

  task automatic test_single();
    logic [159:0] v, hv, ov, bv, exp;
    do_reset();
    drive_and_capture(50, 0, 8'hA5, -1, 8'h00, -1, 8'h00, v, hv, ov, bv);
    exp = line_model(1, 8'hA5, 8'h00, 8'h00);
    total++;
    if (v !== exp) begin
      bad++;
      $display("FAIL single_line: got %h want %h", v, exp);
    end
    total++;
    if ({bv[0], bv[40], bv[41], bv[49]} !== 4'b1100) begin
      bad++;
      $display("FAIL single_busy: got %b want 1100", {bv[0], bv[40], bv[41], bv[49]});
    end
    total++;
    if (bus.bytes_sent !== 16'd1) begin
      bad++;
      $display("FAIL single_count: got %0d want 1", bus.bytes_sent);
    end
  endtask

  task automatic test_back_to_back();
    logic [159:0] v, hv, ov, bv, exp;
    do_reset();
    drive_and_capture(90, 0, 8'h01, 2, 8'hFF, -1, 8'h00, v, hv, ov, bv);
    exp = line_model(2, 8'h01, 8'hFF, 8'h00);
    total++;
    if (v !== exp) begin
      bad++;
      $display("FAIL b2b_line: got %h want %h", v, exp);
    end
    total++;
    if ({hv[1], hv[2], hv[40], hv[41]} !== 4'b0110) begin
      bad++;
      $display("FAIL b2b_hold: got %b want 0110", {hv[1], hv[2], hv[40], hv[41]});
    end
    total++;
    if (ov !== '0) begin
      bad++;
      $display("FAIL b2b_overrun: got %h want 0", ov);
    end
    total++;
    if ({bv[80], bv[81], bus.bytes_sent} !== {1'b1, 1'b0, 16'd2}) begin
      bad++;
      $display("FAIL b2b_end: got busy=%b%b sent=%0d want busy=10 sent=2",
               bv[80], bv[81], bus.bytes_sent);
    end
  endtask

  task automatic test_overrun();
    logic [159:0] v, hv, ov, bv, exp;
    do_reset();
    drive_and_capture(130, 0, 8'h11, 2, 8'h22, 4, 8'h33, v, hv, ov, bv);
    exp = line_model(2, 8'h11, 8'h22, 8'h00);
    total++;
    if (v !== exp) begin
      bad++;
      $display("FAIL ovr_line: got %h want %h", v, exp);
    end
    total++;
    if ({ov[3], ov[4], ov[129]} !== 3'b011) begin
      bad++;
      $display("FAIL ovr_sticky: got %b want 011", {ov[3], ov[4], ov[129]});
    end
    total++;
    if ({bus.hold_full, bus.bytes_sent} !== {1'b0, 16'd2}) begin
      bad++;
      $display("FAIL ovr_end: got hold=%b sent=%0d want hold=0 sent=2",
               bus.hold_full, bus.bytes_sent);
    end
  endtask

  task automatic test_stop_edge_accept();
    logic [159:0] v, hv, ov, bv, exp;
    do_reset();
    drive_and_capture(130, 0, 8'hC3, 2, 8'h5A, 41, 8'hE7, v, hv, ov, bv);
    exp = line_model(3, 8'hC3, 8'h5A, 8'hE7);
    total++;
    if (v !== exp) begin
      bad++;
      $display("FAIL edge_line: got %h want %h", v, exp);
    end
    total++;
    if ({hv[40], hv[41], hv[80], hv[81]} !== 4'b1110) begin
      bad++;
      $display("FAIL edge_hold: got %b want 1110", {hv[40], hv[41], hv[80], hv[81]});
    end
    total++;
    if ({ov, bus.bytes_sent} !== {160'd0, 16'd3}) begin
      bad++;
      $display("FAIL edge_status: got ovr=%h sent=%0d want ovr=0 sent=3", ov, bus.bytes_sent);
    end
  endtask

  task automatic test_disable();
    logic [159:0] v, hv, ov, bv;
    do_reset();
    bus.tx_enable = 1'b0;
    drive_and_capture(50, 0, 8'h3C, 1, 8'h3C, -1, 8'h00, v, hv, ov, bv);
    bus.tx_enable = 1'b1;
    total++;
    if (v !== '1) begin
      bad++;
      $display("FAIL dis_line: got %h want all ones", v);
    end
    total++;
    if ({hv, ov, bv, bus.bytes_sent} !== '0) begin
      bad++;
      $display("FAIL dis_status: got hold=%h ovr=%h busy=%h sent=%0d want all 0",
               hv, ov, bv, bus.bytes_sent);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [159:0] v, hv, ov, bv, exp;
    do_reset();
    drive_and_capture(10, 0, 8'h55, 2, 8'hAA, 4, 8'h33, v, hv, ov, bv);
    // Now inside data bit 1 of 0x55, which drives the line low.
    total++;
    if ({bus.uart_txd, bus.hold_full, bus.overrun, bus.tx_busy} !== 4'b0111) begin
      bad++;
      $display("FAIL midrst_pre: got %b want 0111",
               {bus.uart_txd, bus.hold_full, bus.overrun, bus.tx_busy});
    end
    #2;
    puc_rst = 1'b1;
    #1;
    total++;
    if ({bus.uart_txd, bus.tx_busy, bus.hold_full, bus.overrun, bus.bytes_sent} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL midrst_async: got txd=%b busy=%b hold=%b ovr=%b sent=%0d want 1 0 0 0 0",
               bus.uart_txd, bus.tx_busy, bus.hold_full, bus.overrun, bus.bytes_sent);
    end
    tick();
    tick();
    puc_rst = 1'b0;
    tick();
    drive_and_capture(50, 0, 8'h0F, -1, 8'h00, -1, 8'h00, v, hv, ov, bv);
    exp = line_model(1, 8'h0F, 8'h00, 8'h00);
    total++;
    if (v !== exp) begin
      bad++;
      $display("FAIL midrst_frame: got %h want %h", v, exp);
    end
    total++;
    if ({bus.bytes_sent, ov[49]} !== {16'd1, 1'b0}) begin
      bad++;
      $display("FAIL midrst_count: got sent=%0d ovr=%b want sent=1 ovr=0",
               bus.bytes_sent, ov[49]);
    end
  endtask

  initial begin
    bus.tx_trigger = 1'b0;
    bus.tx_byte    = 8'h00;
    bus.tx_enable  = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_stop_edge_accept();
    test_disable();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
